count_updown_param: RTL
=======================

// Module: count_updown_param
// PURPOSE
//  Parametrised successor to the fixed 4-bit down counter driving the board LEDs.
//  Adds programmable width and terminal value, plus an internal prescaler replacing the ad-hoc timebase/flip-flop divider.
//  Adds up/down/bounce/hold modes, parallel load, wrap-or-saturate policy and a terminal-count strobe.
//  Sits between the board clock/KEY logic and the LED outputs; count[] maps directly onto LED[WIDTH-1:0].
// PARAMETERS
//  WIDTH    4   counter width in bits (1..16)
//  MAX_VAL  15  terminal count for up/bounce; must be <= 2^WIDTH-1
//  DIV      1   prescaler ratio; counter steps once per DIV enabled CLOCK cycles (1 = every cycle, board build uses 5_000_000)
//  WRAP     1   1 = wrap at terminal value; 0 = saturate and stop at terminal value
// PORTS
//  CLOCK     in   1       system clock; all state changes on posedge
//  RESET     in   1       synchronous, active-high reset
//  en        in   1       count enable; gates the prescaler and stepping
//  mode      in   2       00 = down, 01 = up, 10 = bounce (ping-pong 0..MAX_VAL), 11 = hold
//  load      in   1       synchronous parallel load strobe
//  load_val  in   WIDTH   value to load; values > MAX_VAL are clamped to MAX_VAL
//  count     out  WIDTH   current count (registered)
//  tick      out  1       one-cycle strobe, high on each cycle where a step is taken
//  tc        out  1       one-cycle strobe, terminal-count event (registered)
// BEHAVIOUR
//  Reset (RESET=1 at posedge): count=0, prescaler=0, tick=0, tc=0, bounce_dir=up. RESET overrides load and en.
//  Priority on each edge: RESET > load > step > hold.
//  Prescaler:
//   - Counts 0..DIV-1 only while en=1 and mode!=11; frozen otherwise (value kept).
//   - A step occurs on the cycle where the prescaler==DIV-1; the prescaler then returns to 0.
//   - DIV=1 gives a step on every enabled cycle.
//   - tick is combinational from the step condition, aligned with the count update edge.
//  Load:
//   - count <= min(load_val, MAX_VAL); prescaler <= 0; bounce_dir <= up; tc <= 0.
//   - Load wins over a coincident step; no step is taken that cycle.
//  Step, mode 00 (down):
//   - count>0: count-1.
//   - count==0: WRAP=1 -> MAX_VAL with tc=1; WRAP=0 -> stays 0 with tc=1 on the first attempt only.
//  Step, mode 01 (up):
//   - count<MAX_VAL: count+1.
//   - count==MAX_VAL: WRAP=1 -> 0 with tc=1; WRAP=0 -> stays MAX_VAL with tc=1 on the first attempt only.
//  Step, mode 10 (bounce):
//   - Moves in bounce_dir.
//   - At MAX_VAL going up: dir flips to down, count -> MAX_VAL-1, tc=1.
//   - At 0 going down: dir flips to up, count -> 1, tc=1.
//   - WRAP is ignored in this mode. MAX_VAL=0 holds at 0 with tc on every step.
//  Mode 11: count holds, no tick, tc=0.
//  Mode change mid-count:
//   - Takes effect on the next step; count is preserved.
//   - Entering bounce uses the current bounce_dir.
//  Count above MAX_VAL is unreachable except via reset/load paths, both of which are clamped.
//  tc latency: registered, high in the cycle after the terminal step edge, for exactly 1 cycle.
//  Saturate "first attempt" is tracked by a sticky flag, cleared by load, reset, or any non-terminal step.
// TESTING
//  RESET=1 for 2 cycles, en=1, mode=00, DIV=1, WIDTH=4, MAX=15 -> count 0,15,14,...; tc pulses once after each 0->15.
//  mode=01, WRAP=0, load_val=13 -> count 13,14,15,15,15; tc high exactly once, tick every cycle.
//  mode=10, MAX_VAL=3, from 0 -> count 0,1,2,3,2,1,0,1; tc after reaching 3 and after reaching 0.
//  DIV=4, mode=01, en toggled low for 3 cycles mid-period -> step every 4 enabled cycles; prescaler resumes without loss.
//  load=1 coincident with step and load_val=20 (WIDTH=5, MAX=17) -> count=17, no step, prescaler=0.
//  RESET asserted mid-count at count=9 with load=1 -> count=0 next edge, tc=0, tick=0.

Source files
------------

// File: rtl/count_updown_param.sv
// Programmable up/down/bounce counter with prescaler, parallel load, wrap-or-saturate and terminal-count strobe.
// Latency: count and tc are registered (tc lands the cycle after the terminal step); tick is combinational with the step.
// Backpressure: none; en and mode==hold freeze the prescaler and the count in place.
module count_updown_param #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15,
  parameter int DIV     = 1,
  parameter int WRAP    = 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  typedef enum logic [1:0] {
    M_DOWN   = 2'b00,
    M_UP     = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_t;

  // A 1-bit prescaler is kept for DIV=1 so the port widths stay legal; it never leaves 0.
  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]    presc;
  logic             dir_up;     // bounce direction, 1 = counting up
  logic             sat_seen;   // saturate attempt already flagged with tc
  logic             active;
  logic             at_last;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             tc_nxt;
  logic             sat_nxt;

  assign active       = en && (mode_t'(mode) != M_HOLD);
  assign at_last      = (presc == PRE_LAST);
  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

  // A step is only real if neither reset nor load pre-empts it on this edge.
  assign tick = !RESET && !load && active && at_last;

  // Result of one step in the current mode, applied only when tick is high.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir_up;
    tc_nxt    = 1'b0;
    sat_nxt   = 1'b0;
    case (mode_t'(mode))
      M_DOWN: begin
        if (count != '0) begin
          count_nxt = count - WIDTH'(1);
        end else if (WRAP != 0) begin
          count_nxt = MAXV;
          tc_nxt    = 1'b1;
        end else begin
          // Saturated at zero: flag only the first attempt.
          tc_nxt  = !sat_seen;
          sat_nxt = 1'b1;
        end
      end
      M_UP: begin
        if (count < MAXV) begin
          count_nxt = count + WIDTH'(1);
        end else if (WRAP != 0) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
        end else begin
          tc_nxt  = !sat_seen;
          sat_nxt = 1'b1;
        end
      end
      M_BOUNCE: begin
        if (MAXV == '0) begin
          // Degenerate range: pinned at zero, every step is terminal.
          tc_nxt = 1'b1;
        end else if (dir_up) begin
          if (count >= MAXV) begin
            dir_nxt   = 1'b0;
            count_nxt = MAXV - WIDTH'(1);
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            dir_nxt   = 1'b1;
            count_nxt = WIDTH'(1);
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State update: reset, then load, then prescaled step; tc is a single-cycle registered strobe.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count    <= '0;
      presc    <= '0;
      dir_up   <= 1'b1;
      sat_seen <= 1'b0;
      tc       <= 1'b0;
    end else if (load) begin
      count    <= load_clamped;
      presc    <= '0;
      dir_up   <= 1'b1;
      sat_seen <= 1'b0;
      tc       <= 1'b0;
    end else if (active) begin
      if (at_last) begin
        presc    <= '0;
        count    <= count_nxt;
        dir_up   <= dir_nxt;
        sat_seen <= sat_nxt;
        tc       <= tc_nxt;
      end else begin
        presc <= presc + PW'(1);
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
